muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the execute stage, replacing the divide-only multi-cycle path next to the ALU. It accepts one signed or unsigned MULT/DIV operation per handshake, computes it over WIDTH+1 cycles with a shift-add multiplier or a restoring divider, and returns a 2·WIDTH result in `{hi, lo}` form for the HI/LO register path. Flush and a result-side ready allow it to sit behind pipeline stalls.

## Interface
Parameters:
- `WIDTH`, 32: operand width; any value ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous abort of any in-flight or held operation.
- `opn_valid`  in  1  operands and `op` are valid.
- `opn_ready`  out  1  unit can accept an operation (high only in IDLE, not during `rst`).
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  multiplicand / dividend.
- `b`  in  WIDTH  multiplier / divisor.
- `res_valid`  out  1  `result` is valid and held.
- `res_ready`  in  1  consumer takes the result this cycle.
- `result`  out  2·WIDTH  MUL: full product; DIV: {remainder, quotient}.
- `div_by_zero`  out  1  qualifies `result` when `res_valid`: DIV/DIVU with b = 0.
- `busy`  out  1  high in CALC, SIGN and DONE.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE: on `opn_valid & opn_ready` latch op, operand magnitudes (absolute value for signed ops, raw for unsigned), and sign flags; clear counter. Go to CALC. Exception: DIV/DIVU with b = 0 goes directly to DONE.
- CALC: one iteration per cycle, counter increments; after WIDTH iterations go to SIGN.
  - Multiply: shift-add on a 2·WIDTH accumulator, LSB-first on the multiplier.
  - Divide: restoring, MSB-first. Partial remainder is WIDTH+1 bits; quotient bit = 1 when trial subtract ≥ 0.
- SIGN: apply sign correction and register `result`, then go to DONE.
  - MULT: negate the product if sign(a) ≠ sign(b).
  - DIV: negate the quotient if sign(a) ≠ sign(b); the remainder takes the sign of the dividend (truncation toward zero).
  - Unsigned ops: no correction.
- DONE: `res_valid` = 1. `result` and `div_by_zero` stay stable until `res_ready`, then go to IDLE on the next edge.
- Divide by zero: `result` = {a, all-ones}, `div_by_zero` = 1.
- Signed overflow (DIV of MIN by −1): quotient = MIN, remainder = 0, no flag.
- `flush` (and `rst`): next state IDLE, `res_valid` = 0, result discarded. Flush wins over a simultaneous `opn_valid` handshake and over `res_ready`.
- Reset values: `res_valid` 0, `result` 0, `div_by_zero` 0, `busy` 0, counter 0, state IDLE. `opn_ready` is 0 while `rst` is high and 1 the cycle after.

## Timing
- Handshake at edge E0 → CALC iterations at edges E1..E_WIDTH → SIGN registers the result at edge E_WIDTH+1. `res_valid` is high from that edge, so latency is WIDTH+1 cycles (33 for WIDTH = 32).
- Divide by zero: `res_valid` is high 1 cycle after the handshake edge.
- No new operation is accepted until the cycle after the DONE→IDLE edge, so throughput is one operation per WIDTH+3 cycles minimum.
- `res_valid` is never asserted combinationally. `opn_ready` is a combinational decode of state IDLE & !`rst`.
- Inputs `a`, `b`, `op` are sampled only at the handshake edge; later changes have no effect.
- Back-pressure: with `res_ready` held low, `result` must stay bit-stable for any number of cycles.

## Test plan
- MULT (WIDTH = 32): a = 0xFFFFFFFE (−2), b = 3 → `result` = 0xFFFFFFFF_FFFFFFFA, `res_valid` exactly 33 cycles after the handshake. MULTU with the same operands → 0x00000002_FFFFFFFA.
- DIV: a = −7, b = 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). DIVU: 7 / 2 → {1, 3}.
- DIV overflow: a = 0x80000000, b = 0xFFFFFFFF → {0, 0x80000000}, `div_by_zero` = 0. DIVU a = 5, b = 0 → {5, 0xFFFFFFFF}, `div_by_zero` = 1, `res_valid` 1 cycle after the handshake.
- Back-pressure: hold `res_ready` = 0 for 10 cycles after `res_valid` → `result` stable, `opn_ready` = 0; then pulse `res_ready` → `opn_ready` = 1 the next cycle.
- Flush mid-CALC at iteration 10, then issue MULTU 3×4 → no `res_valid` for the flushed op; new result = 12 after 33 cycles. Flush coincident with `opn_valid` → operation not accepted.
- Reset asserted in DONE → `res_valid`, `result`, `busy` = 0 the next cycle. WIDTH = 8 instance: DIV −128 / 3 → quotient −42 (0xD6), remainder −2 (0xFE), latency 9.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider
// sharing one {hi, lo} working register, with signed correction on the way out.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               opn_valid,
  output logic               opn_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opb;

  logic             accept;
  logic             op_div;
  logic             op_signed;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             q_bit;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Operand decode and per-iteration datapath
  assign opn_ready = (state == IDLE) && !rst;
  assign accept    = opn_valid && opn_ready && !flush;
  assign op_div    = op[1];
  assign op_signed = op[0];
  assign b_zero    = (b == '0);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  // Multiply step adds the multiplicand when the current multiplier LSB is set
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  // Divide step brings down the next dividend bit and trials the divisor
  assign div_shift = {hi, lo[WIDTH-1]};
  assign q_bit     = (div_shift >= {1'b0, opb});

  assign prod_mag  = {hi, lo};
  assign prod_fix  = neg_res ? -prod_mag : prod_mag;
  assign quo_fix   = neg_res ? -lo : lo;
  assign rem_fix   = neg_rem ? -hi : hi;

  // Next-state decode; rst and flush always return to IDLE
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = (op_div && b_zero) ? DONE : CALC;
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_n = SIGN;
      SIGN: state_n = DONE;
      DONE: if (res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (rst || flush) state_n = IDLE;
  end

  // State register plus registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      res_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
    end
  end

  // Operand capture, iteration and result registration
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      opb         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            is_div  <= op_div;
            neg_res <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= op_signed && op_div && a[WIDTH-1];
            hi      <= '0;
            lo      <= op_div ? a_mag : b_mag;
            opb     <= op_div ? b_mag : a_mag;
            if (op_div && b_zero) begin
              result      <= {a, {WIDTH{1'b1}}};
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            hi <= q_bit ? WIDTH'(div_shift - {1'b0, opb}) : div_shift[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], q_bit};
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
        end
        SIGN: result <= is_div ? {rem_fix, quo_fix} : prod_fix;
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with a per-cycle compare
// process on the 32-bit instance, directed corner cases, and an 8-bit instance.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           flush;
  logic           opn_valid;
  logic           opn_ready;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] result;
  logic           div_by_zero;
  logic           busy;

  logic           opn_valid8;
  logic           opn_ready8;
  logic [1:0]     op8;
  logic [7:0]     a8;
  logic [7:0]     b8;
  logic           res_valid8;
  logic [15:0]    result8;
  logic           div_by_zero8;
  logic           busy8;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .opn_valid(opn_valid), .opn_ready(opn_ready), .op(op), .a(a), .b(b),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .opn_valid(opn_valid8), .opn_ready(opn_ready8), .op(op8), .a(a8), .b(b8),
    .res_valid(res_valid8), .res_ready(res_ready), .result(result8),
    .div_by_zero(div_by_zero8), .busy(busy8)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit chk_en     = 1'b0;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain integer arithmetic (truncating division)
  function automatic logic [64:0] model32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] pr, qr, rr;
    sx = o[0] ? longint'($signed(x)) : longint'(x);
    sy = o[0] ? longint'($signed(y)) : longint'(y);
    if (!o[1]) begin
      p  = sx * sy;
      pr = p;
      return {1'b0, pr};
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    q  = sx / sy;
    r  = sx % sy;
    qr = q;
    rr = r;
    return {1'b0, rr[31:0], qr[31:0]};
  endfunction

  function automatic logic [16:0] model8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int sx, sy, p, q, r;
    logic [31:0] pr, qr, rr;
    sx = o[0] ? int'($signed(x)) : int'(x);
    sy = o[0] ? int'($signed(y)) : int'(y);
    if (!o[1]) begin
      p  = sx * sy;
      pr = p;
      return {1'b0, pr[15:0]};
    end
    if (y == 8'd0) return {1'b1, x, 8'hFF};
    q  = sx / sy;
    r  = sx % sy;
    qr = q;
    rr = r;
    return {1'b0, rr[7:0], qr[7:0]};
  endfunction

  // Per-cycle compare against the model: one op in flight, result due W+1 edges after accept
  logic        m_busy;
  logic        m_rv;
  logic [64:0] m_e;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      m_busy = (sb.size() != 0);
      m_rv   = 1'b0;
      if (m_busy) m_rv = (cyc >= sb[0].due);
      check("opn_ready", 64'(opn_ready), 64'(!m_busy && !rst));
      check("busy", 64'(busy), 64'(m_busy));
      check("res_valid", 64'(res_valid), 64'(m_rv));
      if (m_rv && res_valid) begin
        check("result", result, sb[0].res);
        check("div_by_zero", 64'(div_by_zero), 64'(sb[0].dbz));
      end
      if (rst || flush) sb.delete();
      else if (m_busy) begin
        if (m_rv && res_ready) void'(sb.pop_front());
      end else if (opn_valid) begin
        m_e = model32(op, a, b);
        sb.push_back('{res: m_e[63:0], dbz: m_e[64], due: cyc + (m_e[64] ? 1 : int'(W) + 2)});
      end
    end
    cyc++;
  end

  task automatic finish_bench();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit rand_rr);
    int n;
    n = 0;
    while (!opn_ready && n < 300) begin
      if (rand_rr) res_ready = 1'($urandom);
      tick();
      n++;
    end
    if (!opn_ready) begin
      check("issue_timeout", 64'(opn_ready), 64'd1);
      finish_bench();
    end
    op = o; a = x; b = y; opn_valid = 1'b1;
    if (!rand_rr) res_ready = 1'b0;
    tick();
    opn_valid = 1'b0;
    scramble();
  endtask

  // Edges after the handshake edge until res_valid is seen
  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!res_valid) check("res_valid_timeout", 64'(res_valid), 64'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output logic [15:0] r);
    int n;
    logic [16:0] e;
    e = model8(o, x, y);
    n = 0;
    while (!opn_ready8 && n < 100) begin
      tick();
      n++;
    end
    op8 = o; a8 = x; b8 = y; opn_valid8 = 1'b1; res_ready = 1'b0;
    tick();
    opn_valid8 = 1'b0;
    op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (!res_valid8 && n < 50) begin
      tick();
      n++;
    end
    check("w8_latency", 64'(n), e[16] ? 64'd0 : 64'd9);
    check("w8_result", 64'(result8), 64'(e[15:0]));
    check("w8_dbz", 64'(div_by_zero8), 64'(e[16]));
    r = result8;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    logic [15:0] r8;

    rst = 1'b1; flush = 1'b0; opn_valid = 1'b0; res_ready = 1'b0;
    opn_valid8 = 1'b0; op8 = 2'd0; a8 = 8'd0; b8 = 8'd0;
    scramble();
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_result", result, 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_opn_ready", 64'(opn_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_opn_ready", 64'(opn_ready), 64'd1);

    // Signed and unsigned products of -2 and 3
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_res(lat);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_result", result, 64'hFFFF_FFFF_FFFF_FFFA);
    consume();
    check("ready_after_done", 64'(opn_ready), 64'd1);

    issue(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_res(lat);
    check("multu_result", result, 64'h0000_0002_FFFF_FFFA);
    consume();

    // Division sign rules, overflow and divide by zero
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_res(lat);
    check("div_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
    consume();

    issue(2'b10, 32'd7, 32'd2, 1'b0);
    wait_res(lat);
    check("divu_result", result, 64'h0000_0001_0000_0003);
    consume();

    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_res(lat);
    check("div_ovf_result", result, 64'h0000_0000_8000_0000);
    check("div_ovf_dbz", 64'(div_by_zero), 64'd0);
    consume();

    issue(2'b10, 32'd5, 32'd0, 1'b0);
    wait_res(lat);
    check("dbz_latency", 64'(lat), 64'd0);
    check("dbz_result", result, 64'h0000_0005_FFFF_FFFF);
    check("dbz_flag", 64'(div_by_zero), 64'd1);
    consume();

    // Back-pressure: result held with res_ready low
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_res(lat);
    repeat (10) tick();
    check("bp_result", result, 64'h0B00_EA4E_242D_2080);
    check("bp_res_valid", 64'(res_valid), 64'd1);
    check("bp_opn_ready", 64'(opn_ready), 64'd0);
    consume();
    check("bp_ready_after", 64'(opn_ready), 64'd1);

    // Flush at iteration 10, then a fresh op
    issue(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_res_valid", 64'(res_valid), 64'd0);
    issue(2'b00, 32'd3, 32'd4, 1'b0);
    wait_res(lat);
    check("post_flush_latency", 64'(lat), 64'd33);
    check("post_flush_result", result, 64'd12);
    consume();

    // Flush coincident with a handshake drops the op
    op = 2'b00; a = 32'd9; b = 32'd9; opn_valid = 1'b1; flush = 1'b1;
    tick();
    opn_valid = 1'b0; flush = 1'b0;
    check("flush_hs_busy", 64'(busy), 64'd0);
    check("flush_hs_ready", 64'(opn_ready), 64'd1);
    tick();

    // Reset while holding a result
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    wait_res(lat);
    rst = 1'b1;
    tick();
    check("rst_done_res_valid", 64'(res_valid), 64'd0);
    check("rst_done_result", result, 64'd0);
    check("rst_done_busy", 64'(busy), 64'd0);
    check("rst_done_opn_ready", 64'(opn_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_done_ready_after", 64'(opn_ready), 64'd1);

    // Random ops with random back-pressure and occasional flush
    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom), pick(), pick(), 1'b1);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 40)) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
    end
    res_ready = 1'b1;
    n = 0;
    while (!opn_ready && n < 100) begin
      tick();
      n++;
    end
    check("drain_ready", 64'(opn_ready), 64'd1);
    res_ready = 1'b0;
    tick();

    // 8-bit instance
    run8(2'b11, 8'h80, 8'h03, r8);
    check("w8_div_literal", 64'(r8), 64'h0000_FED6);
    run8(2'b10, 8'h2A, 8'h00, r8);
    check("w8_dbz_literal", 64'(r8), 64'h0000_2AFF);
    for (int i = 0; i < 20; i++) begin
      run8(2'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom), r8);
    end

    tick();
    finish_bench();
  end

endmodule
